// File: rtl/pps_mem_access_pkg.sv
// Shared constants, types and lane helpers for the MIPS1000 memory-access stage.
package pps_mem_access_pkg;

    localparam int MEM_OP_TYPE_SIZE = 7;
    localparam int RWE_SIZE         = 1;

    localparam int MEM_TYPE_LB    = 0;
    localparam int MEM_TYPE_LBU   = 1;
    localparam int MEM_TYPE_LH    = 2;
    localparam int MEM_TYPE_LHU   = 3;
    localparam int MEM_TYPE_LW    = 4;
    localparam int MEM_TYPE_RSVD0 = 5;
    localparam int MEM_TYPE_RSVD1 = 6;

    localparam logic [3:0] MEM_BE_BYTE0   = 4'b0001;
    localparam logic [3:0] MEM_BE_HALF_LO = 4'b0011;
    localparam logic [3:0] MEM_BE_HALF_HI = 4'b1100;
    localparam logic [3:0] MEM_BE_WORD    = 4'b1111;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    // Reserved type encodings fall through to word accesses.
    function automatic size_e type_size(input logic [MEM_OP_TYPE_SIZE-1:0] t);
        size_e sz;
        case (1'b1)
            t[MEM_TYPE_LB], t[MEM_TYPE_LBU]:                     sz = SZ_BYTE;
            t[MEM_TYPE_LH], t[MEM_TYPE_LHU]:                     sz = SZ_HALF;
            t[MEM_TYPE_LW], t[MEM_TYPE_RSVD0], t[MEM_TYPE_RSVD1]: sz = SZ_WORD;
            default:                                             sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic [3:0] calc_be(input size_e sz, input logic [1:0] a);
        logic [3:0] be;
        case (sz)
            SZ_BYTE: be = MEM_BE_BYTE0 << a;
            SZ_HALF: be = a[1] ? MEM_BE_HALF_HI : MEM_BE_HALF_LO;
            default: be = MEM_BE_WORD;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] calc_wdata(input size_e sz, input logic [31:0] d);
        logic [31:0] w;
        case (sz)
            SZ_BYTE: w = {4{d[7:0]}};
            SZ_HALF: w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic misaligned(input size_e sz, input logic [1:0] a);
        logic m;
        case (sz)
            SZ_HALF: m = a[0];
            SZ_WORD: m = |a;
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/pps_load_align.sv
// Load lane selection and sign/zero extension of SRAM read data.
module pps_load_align
    import pps_mem_access_pkg::*;
(
    input  logic [31:0]                 rdata_i,
    input  logic [1:0]                  lane_i,
    input  logic [MEM_OP_TYPE_SIZE-1:0] type_i,
    output logic [31:0]                 data_o
);

    size_e       size_s;
    logic        sext_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign size_s = type_size(type_i);
    assign sext_s = type_i[MEM_TYPE_LB] | type_i[MEM_TYPE_LH];

    // Lane pick and extension.
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        data_o = 32'h0000_0000;
        case (lane_i)
            2'd0:    byte_s = rdata_i[7:0];
            2'd1:    byte_s = rdata_i[15:8];
            2'd2:    byte_s = rdata_i[23:16];
            2'd3:    byte_s = rdata_i[31:24];
            default: byte_s = 8'h00;
        endcase
        if (lane_i[1]) begin
            half_s = rdata_i[31:16];
        end else begin
            half_s = rdata_i[15:0];
        end
        case (size_s)
            SZ_BYTE: data_o = {{24{sext_s & byte_s[7]}}, byte_s};
            SZ_HALF: data_o = {{16{sext_s & half_s[15]}}, half_s};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/pps_mem_access.sv
// MIPS1000 memory-access stage: SRAM req/ack FSM and registered write-back result.
// Optional feature: MEM_ALIGN_CHECK_EN traps misaligned half/word accesses.
module pps_mem_access
    import pps_mem_access_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [31:0]                 EX_ALUOut_in,
    input  logic [31:0]                 EX_STData_in,
    input  logic [4:0]                  EX_inst_rd_in,
    input  logic [RWE_SIZE-1:0]         EX_RegWrite_in,
    input  logic                        EX_memop_in,
    input  logic                        EX_memwr_in,
    input  logic [MEM_OP_TYPE_SIZE-1:0] EX_memop_type_in,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [3:0]                  mem_be,
    output logic [31:0]                 mem_addr,
    output logic [31:0]                 mem_wdata,
    input  logic [31:0]                 mem_rdata,
    input  logic                        mem_ack,
    output logic                        MEM_stall_out,
    output logic [31:0]                 MEM_result_out,
    output logic [4:0]                  MEM_inst_rd_out,
    output logic [RWE_SIZE-1:0]         MEM_RegWrite_out,
    output logic                        MEM_exc_out
);

    state_e                      state_q, state_d;
    logic                        mem_req_q, mem_req_d;
    logic                        mem_we_q, mem_we_d;
    logic [3:0]                  mem_be_q, mem_be_d;
    logic [31:0]                 mem_addr_q, mem_addr_d;
    logic [31:0]                 mem_wdata_q, mem_wdata_d;
    logic [MEM_OP_TYPE_SIZE-1:0] type_q, type_d;
    logic [1:0]                  lane_q, lane_d;
    logic [4:0]                  rd_q, rd_d;
    logic [RWE_SIZE-1:0]         rw_q, rw_d;
    logic [31:0]                 res_q, res_d;
    logic [4:0]                  res_rd_q, res_rd_d;
    logic [RWE_SIZE-1:0]         res_rw_q, res_rw_d;
    logic                        stall_s;
    logic                        misalign_s;
    size_e                       size_s;
    logic [31:0]                 load_data_s;

    assign size_s = type_size(EX_memop_type_in);

`ifdef MEM_ALIGN_CHECK_EN
    logic exc_q, exc_d;
    assign misalign_s  = misaligned(size_s, EX_ALUOut_in[1:0]);
    assign MEM_exc_out = exc_q;
`else
    assign misalign_s  = 1'b0;
    assign MEM_exc_out = 1'b0;
`endif

    pps_load_align u_load_align (
        .rdata_i (mem_rdata),
        .lane_i  (lane_q),
        .type_i  (type_q),
        .data_o  (load_data_s)
    );

    // Next-state, SRAM request and write-back result selection.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        type_d      = type_q;
        lane_d      = lane_q;
        rd_d        = rd_q;
        rw_d        = rw_q;
        res_d       = res_q;
        res_rd_d    = res_rd_q;
        res_rw_d    = res_rw_q;
        stall_s     = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        exc_d       = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (EX_memop_in && misalign_s) begin
                    // Trapped access: faulting address goes to write-back, no SRAM cycle.
                    res_d    = EX_ALUOut_in;
                    res_rd_d = EX_inst_rd_in;
                    res_rw_d = {RWE_SIZE{1'b0}};
`ifdef MEM_ALIGN_CHECK_EN
                    exc_d    = 1'b1;
`endif
                end else if (EX_memop_in) begin
                    stall_s     = 1'b1;
                    state_d     = ST_ACCESS;
                    mem_req_d   = 1'b1;
                    mem_we_d    = EX_memwr_in;
                    mem_be_d    = calc_be(size_s, EX_ALUOut_in[1:0]);
                    mem_addr_d  = {EX_ALUOut_in[31:2], 2'b00};
                    mem_wdata_d = calc_wdata(size_s, EX_STData_in);
                    type_d      = EX_memop_type_in;
                    lane_d      = EX_ALUOut_in[1:0];
                    rd_d        = EX_inst_rd_in;
                    rw_d        = EX_RegWrite_in;
                    res_rw_d    = {RWE_SIZE{1'b0}};
                end else begin
                    res_d    = EX_ALUOut_in;
                    res_rd_d = EX_inst_rd_in;
                    res_rw_d = EX_RegWrite_in;
                end
            end
            ST_ACCESS: begin
                stall_s = 1'b1;
                if (mem_ack) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    res_rd_d  = rd_q;
                    if (mem_we_q) begin
                        res_d    = 32'h0000_0000;
                        res_rw_d = {RWE_SIZE{1'b0}};
                    end else begin
                        res_d    = load_data_s;
                        res_rw_d = rw_q;
                    end
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
            type_q      <= {MEM_OP_TYPE_SIZE{1'b0}};
            lane_q      <= 2'b00;
            rd_q        <= 5'd0;
            rw_q        <= {RWE_SIZE{1'b0}};
            res_q       <= 32'h0000_0000;
            res_rd_q    <= 5'd0;
            res_rw_q    <= {RWE_SIZE{1'b0}};
`ifdef MEM_ALIGN_CHECK_EN
            exc_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            type_q      <= type_d;
            lane_q      <= lane_d;
            rd_q        <= rd_d;
            rw_q        <= rw_d;
            res_q       <= res_d;
            res_rd_q    <= res_rd_d;
            res_rw_q    <= res_rw_d;
`ifdef MEM_ALIGN_CHECK_EN
            exc_q       <= exc_d;
`endif
        end
    end

    assign mem_req          = mem_req_q;
    assign mem_we           = mem_we_q;
    assign mem_be           = mem_be_q;
    assign mem_addr         = mem_addr_q;
    assign mem_wdata        = mem_wdata_q;
    assign MEM_stall_out    = stall_s;
    assign MEM_result_out   = res_q;
    assign MEM_inst_rd_out  = res_rd_q;
    assign MEM_RegWrite_out = res_rw_q;

endmodule

// File: tb/tb_pps_mem_access.sv
// Scoreboard bench for pps_mem_access; honours MEM_ALIGN_CHECK_EN when defined.
module tb_pps_mem_access;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        rw;
        logic        exc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] EX_ALUOut_in, EX_STData_in, mem_rdata;
    logic [4:0]  EX_inst_rd_in;
    logic [0:0]  EX_RegWrite_in;
    logic        EX_memop_in, EX_memwr_in, mem_ack;
    logic [6:0]  EX_memop_type_in;
    logic        mem_req, mem_we, MEM_stall_out, MEM_exc_out;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, MEM_result_out;
    logic [4:0]  MEM_inst_rd_out;
    logic [0:0]  MEM_RegWrite_out;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t exp;
    exp_t got;

    // Observations captured by run_mem.
    int          o_stall, o_req;
    logic        o_stable, o_req_t, o_rw_acc, o_we;
    logic [3:0]  o_be;
    logic [31:0] o_addr, o_wdata;

    localparam logic [6:0] T_LB = 7'b0000001, T_LBU = 7'b0000010, T_LH = 7'b0000100,
                           T_LHU = 7'b0001000, T_LW = 7'b0010000;

    always #5 clk = ~clk;

    pps_mem_access dut (
        .clk(clk), .rst(rst),
        .EX_ALUOut_in(EX_ALUOut_in), .EX_STData_in(EX_STData_in),
        .EX_inst_rd_in(EX_inst_rd_in), .EX_RegWrite_in(EX_RegWrite_in),
        .EX_memop_in(EX_memop_in), .EX_memwr_in(EX_memwr_in),
        .EX_memop_type_in(EX_memop_type_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .MEM_stall_out(MEM_stall_out), .MEM_result_out(MEM_result_out),
        .MEM_inst_rd_out(MEM_inst_rd_out), .MEM_RegWrite_out(MEM_RegWrite_out),
        .MEM_exc_out(MEM_exc_out)
    );

    // Memory op accepted at T, ack driven at T+k; returns at T+k+1 with EX idle.
    task automatic run_mem(input logic [31:0] addr, input logic [31:0] st, input logic [4:0] rd,
                           input logic wr, input logic [6:0] typ, input int k,
                           input logic [31:0] rdata);
        @(negedge clk);
        EX_ALUOut_in = addr; EX_STData_in = st; EX_inst_rd_in = rd; EX_RegWrite_in = 1'b1;
        EX_memop_in = 1'b1; EX_memwr_in = wr; EX_memop_type_in = typ;
        #1;
        o_stall = MEM_stall_out ? 1 : 0;
        o_req = 0; o_stable = 1'b1; o_req_t = mem_req;
        for (int i = 1; i <= k; i++) begin
            @(negedge clk);
            if (i == k) begin
                mem_ack = 1'b1; mem_rdata = rdata;
            end
            #1;
            if (mem_req) o_req++;
            if (MEM_stall_out) o_stall++;
            if (i == 1) begin
                o_addr = mem_addr; o_be = mem_be; o_wdata = mem_wdata; o_we = mem_we;
                o_rw_acc = MEM_RegWrite_out[0];
            end else if ({o_addr, o_be, o_wdata, o_we} !== {mem_addr, mem_be, mem_wdata, mem_we}) begin
                o_stable = 1'b0;
            end
        end
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 32'h0; EX_memop_in = 1'b0; EX_memwr_in = 1'b0;
        EX_ALUOut_in = 32'h0; EX_RegWrite_in = 1'b0; EX_inst_rd_in = 5'd0;
        #1;
    endtask

    task automatic test_reset();
        logic [109:0] snap;
        repeat (2) @(negedge clk);
        #1;
        snap = {mem_req, mem_we, mem_be, mem_addr, mem_wdata, MEM_result_out,
                MEM_inst_rd_out, MEM_RegWrite_out, MEM_exc_out, MEM_stall_out};
        checks++;
        if (snap !== '0) begin
            errors++; $display("FAIL reset_outputs got %h exp 0", snap);
        end
        rst = 1'b0;
    endtask

    task automatic test_alu();
        @(negedge clk);
        EX_ALUOut_in = 32'h1234_5678; EX_inst_rd_in = 5'd5; EX_RegWrite_in = 1'b1; EX_memop_in = 1'b0;
        exp_q.push_back('{res: 32'h1234_5678, rd: 5'd5, rw: 1'b1, exc: 1'b0});
        #1;
        checks++;
        if ({MEM_stall_out, mem_req} !== 2'b00) begin
            errors++; $display("FAIL alu_stall_req got %b exp 00", {MEM_stall_out, mem_req});
        end
        @(negedge clk);
        EX_ALUOut_in = 32'h0; EX_RegWrite_in = 1'b0; EX_inst_rd_in = 5'd0;
        #1;
        exp = exp_q.pop_front();
        got = {MEM_result_out, MEM_inst_rd_out, MEM_RegWrite_out, MEM_exc_out};
        checks++;
        if (got !== exp || mem_req !== 1'b0) begin
            errors++; $display("FAIL alu_result got %h req %b exp %h req 0", got, mem_req, exp);
        end
    endtask

    task automatic test_lb();
        exp_q.push_back('{res: 32'hFFFF_FF80, rd: 5'd7, rw: 1'b1, exc: 1'b0});
        run_mem(32'h0000_0103, 32'h0, 5'd7, 1'b0, T_LB, 1, 32'h80AA_BBCC);
        checks++;
        if ({o_addr, o_be, o_we, o_rw_acc, o_req_t} !== {32'h0000_0100, 4'b1000, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL lb_bus got addr %h be %b we %b rw %b reqT %b exp 100 1000 0 0 0",
                               o_addr, o_be, o_we, o_rw_acc, o_req_t);
        end
        checks++;
        if (o_stall != 2 || o_req != 1) begin
            errors++; $display("FAIL lb_timing got stall %0d req %0d exp 2 1", o_stall, o_req);
        end
        exp = exp_q.pop_front();
        got = {MEM_result_out, MEM_inst_rd_out, MEM_RegWrite_out, MEM_exc_out};
        checks++;
        if (got !== exp || MEM_stall_out !== 1'b0) begin
            errors++; $display("FAIL lb_result got %h stall %b exp %h stall 0", got, MEM_stall_out, exp);
        end
    endtask

    task automatic test_sh();
        exp_q.push_back('{res: 32'h0, rd: 5'd9, rw: 1'b0, exc: 1'b0});
        run_mem(32'h0000_0202, 32'h0000_BEEF, 5'd9, 1'b1, T_LH, 3, 32'h5555_5555);
        checks++;
        if ({o_addr, o_be, o_wdata, o_we} !== {32'h0000_0200, 4'b1100, 32'hBEEF_BEEF, 1'b1}) begin
            errors++; $display("FAIL sh_bus got addr %h be %b wdata %h we %b exp 200 1100 beefbeef 1",
                               o_addr, o_be, o_wdata, o_we);
        end
        checks++;
        if (o_stall != 4 || o_req != 3 || o_stable !== 1'b1 || o_rw_acc !== 1'b0) begin
            errors++; $display("FAIL sh_timing got stall %0d req %0d stable %b rw %b exp 4 3 1 0",
                               o_stall, o_req, o_stable, o_rw_acc);
        end
        exp = exp_q.pop_front();
        got = {MEM_result_out, MEM_inst_rd_out, MEM_RegWrite_out, MEM_exc_out};
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL sh_result got %h exp %h", got, exp);
        end
    endtask

    task automatic test_loads();
        logic [31:0] addrs [5] = '{32'h0, 32'h0, 32'h2, 32'h1, 32'h2};
        logic [6:0]  types [5] = '{T_LHU, T_LW, T_LH, T_LBU, T_LB};
        logic [31:0] rdats [5] = '{32'h1234_8001, 32'h1234_8001, 32'h8001_1234, 32'h0000_F000, 32'h0012_0000};
        logic [31:0] exps  [5] = '{32'h0000_8001, 32'h1234_8001, 32'hFFFF_8001, 32'h0000_00F0, 32'h0000_0012};
        logic [3:0]  bes   [5] = '{4'b0011, 4'b1111, 4'b1100, 4'b0010, 4'b0100};
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('{res: exps[i], rd: 5'(i + 10), rw: 1'b1, exc: 1'b0});
            run_mem(addrs[i], 32'h0, 5'(i + 10), 1'b0, types[i], 1 + i % 2, rdats[i]);
            checks++;
            if (o_be !== bes[i]) begin
                errors++; $display("FAIL load%0d_be got %b exp %b", i, o_be, bes[i]);
            end
            exp = exp_q.pop_front();
            got = {MEM_result_out, MEM_inst_rd_out, MEM_RegWrite_out, MEM_exc_out};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL load%0d_result got %h exp %h", i, got, exp);
            end
        end
        exp_q.push_back('{res: 32'h0, rd: 5'd3, rw: 1'b0, exc: 1'b0});
        run_mem(32'h0000_0032, 32'h1122_33AB, 5'd3, 1'b1, T_LB, 2, 32'h0);
        checks++;
        if ({o_be, o_wdata} !== {4'b0100, 32'hABAB_ABAB}) begin
            errors++; $display("FAIL sb_bus got be %b wdata %h exp 0100 abababab", o_be, o_wdata);
        end
        exp = exp_q.pop_front();
        got = {MEM_result_out, MEM_inst_rd_out, MEM_RegWrite_out, MEM_exc_out};
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL sb_result got %h exp %h", got, exp);
        end
    endtask

    task automatic test_misaligned();
`ifdef MEM_ALIGN_CHECK_EN
        @(negedge clk);
        EX_ALUOut_in = 32'h6; EX_inst_rd_in = 5'd4; EX_RegWrite_in = 1'b1;
        EX_memop_in = 1'b1; EX_memwr_in = 1'b0; EX_memop_type_in = T_LW;
        exp_q.push_back('{res: 32'h6, rd: 5'd4, rw: 1'b0, exc: 1'b1});
        #1;
        checks++;
        if (MEM_stall_out !== 1'b0) begin
            errors++; $display("FAIL mis_stall got %b exp 0", MEM_stall_out);
        end
        @(negedge clk);
        EX_memop_in = 1'b0; EX_ALUOut_in = 32'h77; EX_inst_rd_in = 5'd1; EX_RegWrite_in = 1'b0;
        exp_q.push_back('{res: 32'h77, rd: 5'd1, rw: 1'b0, exc: 1'b0});
        #1;
        exp = exp_q.pop_front();
        got = {MEM_result_out, MEM_inst_rd_out, MEM_RegWrite_out, MEM_exc_out};
        checks++;
        if (got !== exp || mem_req !== 1'b0) begin
            errors++; $display("FAIL mis_exc got %h req %b exp %h req 0", got, mem_req, exp);
        end
        @(negedge clk);
        EX_ALUOut_in = 32'h0; EX_inst_rd_in = 5'd0;
        #1;
        exp = exp_q.pop_front();
        got = {MEM_result_out, MEM_inst_rd_out, MEM_RegWrite_out, MEM_exc_out};
        checks++;
        if (got !== exp || mem_req !== 1'b0) begin
            errors++; $display("FAIL mis_pulse_end got %h req %b exp %h req 0", got, mem_req, exp);
        end
`else
        exp_q.push_back('{res: 32'h1122_3344, rd: 5'd4, rw: 1'b1, exc: 1'b0});
        run_mem(32'h0000_0006, 32'h0, 5'd4, 1'b0, T_LW, 1, 32'h1122_3344);
        checks++;
        if ({o_addr, o_be} !== {32'h0000_0004, 4'b1111}) begin
            errors++; $display("FAIL mis_lw_bus got addr %h be %b exp 4 1111", o_addr, o_be);
        end
        exp = exp_q.pop_front();
        got = {MEM_result_out, MEM_inst_rd_out, MEM_RegWrite_out, MEM_exc_out};
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL mis_lw_result got %h exp %h", got, exp);
        end
        exp_q.push_back('{res: 32'hFFFF_ABCD, rd: 5'd6, rw: 1'b1, exc: 1'b0});
        run_mem(32'h0000_0003, 32'h0, 5'd6, 1'b0, T_LH, 1, 32'hABCD_0000);
        exp = exp_q.pop_front();
        got = {MEM_result_out, MEM_inst_rd_out, MEM_RegWrite_out, MEM_exc_out};
        checks++;
        if (got !== exp || o_be !== 4'b1100) begin
            errors++; $display("FAIL mis_lh_result got %h be %b exp %h be 1100", got, o_be, exp);
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic [109:0] snap;
        @(negedge clk);
        EX_ALUOut_in = 32'h40; EX_inst_rd_in = 5'd8; EX_RegWrite_in = 1'b1;
        EX_memop_in = 1'b1; EX_memwr_in = 1'b0; EX_memop_type_in = T_LW;
        @(negedge clk);
        EX_memop_in = 1'b0; EX_ALUOut_in = 32'h0; EX_RegWrite_in = 1'b0; EX_inst_rd_in = 5'd0;
        #1;
        checks++;
        if (mem_req !== 1'b1) begin
            errors++; $display("FAIL rstmid_req_before got %b exp 1", mem_req);
        end
        rst = 1'b1;
        #1;
        snap = {mem_req, mem_we, mem_be, mem_addr, mem_wdata, MEM_result_out,
                MEM_inst_rd_out, MEM_RegWrite_out, MEM_exc_out, MEM_stall_out};
        checks++;
        if (snap !== '0) begin
            errors++; $display("FAIL rstmid_outputs got %h exp 0", snap);
        end
        @(negedge clk);
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 32'h0;
        #1;
        checks++;
        if ({MEM_result_out, MEM_RegWrite_out, mem_req, MEM_stall_out} !== 35'h0) begin
            errors++; $display("FAIL rstmid_late_ack got res %h rw %b req %b stall %b exp 0",
                               MEM_result_out, MEM_RegWrite_out, mem_req, MEM_stall_out);
        end
    endtask

    task automatic test_back_to_back();
        exp_q.push_back('{res: 32'hCAFE_0001, rd: 5'd2, rw: 1'b1, exc: 1'b0});
        run_mem(32'h0000_0010, 32'h0, 5'd2, 1'b0, T_LW, 1, 32'hCAFE_0001);
        // Next instruction goes in the cycle right after the ack.
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            if (i < 5) begin
                EX_ALUOut_in = $urandom; EX_inst_rd_in = 5'($urandom_range(0, 31));
                EX_RegWrite_in = 1'($urandom_range(0, 1)); EX_memop_in = 1'b0;
                exp_q.push_back('{res: EX_ALUOut_in, rd: EX_inst_rd_in, rw: EX_RegWrite_in[0], exc: 1'b0});
            end
            #1;
            exp = exp_q.pop_front();
            got = {MEM_result_out, MEM_inst_rd_out, MEM_RegWrite_out, MEM_exc_out};
            checks++;
            if (got !== exp || MEM_stall_out !== 1'b0) begin
                errors++; $display("FAIL b2b%0d got %h stall %b exp %h stall 0", i, got, MEM_stall_out, exp);
            end
        end
        EX_ALUOut_in = 32'h0; EX_RegWrite_in = 1'b0; EX_inst_rd_in = 5'd0;
    endtask

    initial begin
        rst = 1'b1;
        EX_ALUOut_in = 32'h0; EX_STData_in = 32'h0; EX_inst_rd_in = 5'd0; EX_RegWrite_in = 1'b0;
        EX_memop_in = 1'b0; EX_memwr_in = 1'b0; EX_memop_type_in = 7'd0;
        mem_rdata = 32'h0; mem_ack = 1'b0;
        test_reset();
        test_alu();
        test_lb();
        test_sh();
        test_loads();
        test_misaligned();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
